// File: rtl/biu_constants_pkg.sv
// Shared types for the bus interface unit arbiter: access sizes, arbiter
// states and grant encodings.
package biu_constants_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } biu_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/biu_arb_timer.sv
// Transaction watchdog: 16-bit up-counter cleared on grant, counting while
// busy; expired flags the cycle the count equals TIMEOUT (0 = never).
module biu_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (TIMEOUT != 0) && en && (cnt_q == LIMIT);

endmodule

// File: rtl/biu_arbiter.sv
// Two-master (instruction/data) arbiter onto one shared memory port.
// Optional ARB_ROUND_ROBIN_EN: ties go to the master not granted last.
//
//   state  | meaning
//   IDLE   | no owner; a pending request is granted on this edge
//   BUSY_I | instruction fetch owns mem_*; waiting for ack/err/timeout
//   BUSY_D | data access owns mem_*; waiting for ack/err/timeout
module biu_arbiter
    import biu_constants_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            imem_req,
    input  logic [XLEN-1:0] imem_adr,
    output logic [XLEN-1:0] imem_q,
    output logic            imem_ack,
    output logic            imem_err,
    input  logic            dmem_req,
    input  logic            dmem_we,
    input  logic [XLEN-1:0] dmem_adr,
    input  logic [XLEN-1:0] dmem_d,
    input  biu_size_t       dmem_size,
    output logic [XLEN-1:0] dmem_q,
    output logic            dmem_ack,
    output logic            dmem_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_adr,
    output logic [XLEN-1:0] mem_d,
    output biu_size_t       mem_size,
    input  logic [XLEN-1:0] mem_q,
    input  logic            mem_ack,
    input  logic            mem_err,
    output logic [1:0]      arb_gnt
);

    arb_state_t      state_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_adr_q;
    logic [XLEN-1:0] mem_d_q;
    biu_size_t       mem_size_q;
    logic [1:0]      gnt_q;

    logic any_req;
    logic pick_d;
    logic busy;
    logic grant;
    logic expired;
    logic done;

    assign any_req = imem_req | dmem_req;
    assign busy    = (state_q != IDLE);
    assign grant   = (state_q == IDLE) && any_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_data_q;
    assign pick_d = dmem_req & (~imem_req | ~last_data_q);
`else
    assign pick_d = dmem_req;
`endif

    biu_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (grant),
        .en      (busy),
        .expired (expired)
    );

    assign done = busy & (mem_ack | mem_err | expired);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_d_q    <= '0;
            mem_size_q <= SZ_WORD;
            gnt_q      <= GNT_NONE;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        mem_req_q <= 1'b1;
                        if (pick_d) begin
                            state_q    <= BUSY_D;
                            gnt_q      <= GNT_D;
                            mem_adr_q  <= dmem_adr;
                            mem_d_q    <= dmem_d;
                            mem_we_q   <= dmem_we;
                            mem_size_q <= dmem_size;
                        end else begin
                            // fetches are word reads; mem_d keeps its last value
                            state_q    <= BUSY_I;
                            gnt_q      <= GNT_I;
                            mem_adr_q  <= imem_adr;
                            mem_we_q   <= 1'b0;
                            mem_size_q <= SZ_WORD;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_data_q <= pick_d;
`endif
                    end
                end
                default: begin
                    if (done) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        gnt_q     <= GNT_NONE;
                    end
                end
            endcase
        end
    end

    // ack beats a coincident timeout; nothing reaches a requester during reset
    assign imem_ack = rstn & (state_q == BUSY_I) & mem_ack;
    assign imem_err = rstn & (state_q == BUSY_I) & ~mem_ack & (mem_err | expired);
    assign dmem_ack = rstn & (state_q == BUSY_D) & mem_ack;
    assign dmem_err = rstn & (state_q == BUSY_D) & ~mem_ack & (mem_err | expired);

    assign imem_q   = mem_q;
    assign dmem_q   = mem_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_adr  = mem_adr_q;
    assign mem_d    = mem_d_q;
    assign mem_size = mem_size_q;
    assign arb_gnt  = gnt_q;

endmodule

// File: tb/tb_biu_arbiter.sv
// Scoreboard bench for biu_arbiter (TIMEOUT=4): expected grants and
// completions are queued by the stimulus and popped by a negedge monitor.
module tb_biu_arbiter;
    import biu_constants_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_adr;
    logic [31:0] imem_q;
    logic        imem_ack, imem_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_adr, dmem_d;
    biu_size_t   dmem_size;
    logic [31:0] dmem_q;
    logic        dmem_ack, dmem_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_adr, mem_d;
    biu_size_t   mem_size;
    logic [31:0] mem_q;
    logic        mem_ack, mem_err;
    logic [1:0]  arb_gnt;

    int   checks = 0;
    int   errors = 0;
    int   ack_delay = -1;
    int   resp_cnt = 0;
    logic resp_ack = 1'b0;
    logic force_ack = 1'b0;
    logic force_err = 1'b0;
    logic mon_en = 1'b0;

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] adr;
        logic        we;
        logic [31:0] d;
        biu_size_t   size;
    } grant_t;

    typedef struct {
        logic [3:0]  flags;
        logic        chk_q;
        logic [31:0] q;
    } cmpl_t;

    grant_t exp_g[$];
    cmpl_t  exp_c[$];

    always #5 clk = ~clk;

    biu_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req), .imem_adr(imem_adr), .imem_q(imem_q),
        .imem_ack(imem_ack), .imem_err(imem_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr),
        .dmem_d(dmem_d), .dmem_size(dmem_size), .dmem_q(dmem_q),
        .dmem_ack(dmem_ack), .dmem_err(dmem_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_d(mem_d),
        .mem_size(mem_size), .mem_q(mem_q), .mem_ack(mem_ack), .mem_err(mem_err),
        .arb_gnt(arb_gnt)
    );

    // memory model: read data is the inverted address; ack after ack_delay cycles
    assign mem_q   = ~mem_adr;
    assign mem_ack = resp_ack | force_ack;
    assign mem_err = force_err;

    always @(posedge clk) begin
        #1;
        if (mem_req === 1'b1) begin
            resp_ack = (ack_delay >= 0) && (resp_cnt == ack_delay);
            resp_cnt = resp_cnt + 1;
        end else begin
            resp_ack = 1'b0;
            resp_cnt = 0;
        end
    end

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_g(logic [1:0] gnt, logic [31:0] adr, logic we, logic [31:0] d, biu_size_t sz);
        grant_t g;
        g.gnt = gnt; g.adr = adr; g.we = we; g.d = d; g.size = sz;
        exp_g.push_back(g);
    endtask

    task automatic push_c(logic [3:0] flags, logic chk_q, logic [31:0] q);
        cmpl_t c;
        c.flags = flags; c.chk_q = chk_q; c.q = q;
        exp_c.push_back(c);
    endtask

    // monitor: new grants, field stability, completions, post-completion drop
    logic        prev_req = 1'b0;
    logic        prev_done = 1'b0;
    grant_t      cur;
    always @(negedge clk) begin
        if (mon_en) begin
            logic  done_now;
            logic [31:0] q_now;
            grant_t g;
            cmpl_t  c;
            if (mem_req && !prev_req) begin
                if (exp_g.size() == 0) begin
                    chk("grant_unexpected", {arb_gnt, mem_adr}, 0);
                end else begin
                    g = exp_g.pop_front();
                    chk("grant_gnt", arb_gnt, g.gnt);
                    chk("grant_adr", mem_adr, g.adr);
                    chk("grant_we_size", {mem_we, mem_size}, {g.we, g.size});
                    chk("grant_d", mem_d, g.d);
                end
                cur.gnt = arb_gnt; cur.adr = mem_adr; cur.we = mem_we;
                cur.d = mem_d; cur.size = mem_size;
            end else if (mem_req && prev_req) begin
                chk("busy_hold", {arb_gnt, mem_adr, mem_we, mem_d, mem_size},
                    {cur.gnt, cur.adr, cur.we, cur.d, cur.size});
            end
            if (prev_done) chk("req_drop_after_done", mem_req, 1'b0);
            done_now = imem_ack | imem_err | dmem_ack | dmem_err;
            if (done_now) begin
                if (exp_c.size() == 0) begin
                    chk("cmpl_unexpected", {imem_ack, imem_err, dmem_ack, dmem_err}, 4'b0000);
                end else begin
                    c = exp_c.pop_front();
                    chk("cmpl_flags", {imem_ack, imem_err, dmem_ack, dmem_err}, c.flags);
                    q_now = imem_ack ? imem_q : dmem_q;
                    if (c.chk_q) chk("cmpl_q", q_now, c.q);
                end
            end
            prev_req  = mem_req;
            prev_done = done_now;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mreq(string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        if (!mem_req) chk({name, "_mreq_timeout"}, mem_req, 1'b1);
    endtask

    task automatic wait_done(string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_ack | imem_err | dmem_ack | dmem_err) && n < 40);
        if (!(imem_ack | imem_err | dmem_ack | dmem_err))
            chk({name, "_done_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n_ack;
        int cyc;
        logic [1:0] order [4];

        rstn = 1'b0; imem_req = 1'b0; imem_adr = '0;
        dmem_req = 1'b0; dmem_we = 1'b0; dmem_adr = '0; dmem_d = '0; dmem_size = SZ_WORD;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_gnt", {mem_req, arb_gnt}, 3'b000);
        chk("rst_fields", {mem_we, mem_adr, mem_d, mem_size}, {1'b0, 32'h0, 32'h0, SZ_WORD});
        chk("rst_acks", {imem_ack, imem_err, dmem_ack, dmem_err}, 4'b0000);
        mon_en = 1'b1;
        step(); rstn = 1'b1;
        step();

        // simultaneous requests: data first, one idle cycle, then instruction
        ack_delay = 1;
        push_g(GNT_D, 32'h40, 1'b0, 32'hA5A5_0000, SZ_BYTE);
        push_c(4'b0010, 1'b1, 32'hFFFF_FFBF);
        push_g(GNT_I, 32'h200, 1'b0, 32'hA5A5_0000, SZ_WORD);
        push_c(4'b1000, 1'b1, 32'hFFFF_FDFF);
        step();
        imem_adr = 32'h200; dmem_adr = 32'h40; dmem_we = 1'b0;
        dmem_d = 32'hA5A5_0000; dmem_size = SZ_BYTE;
        imem_req = 1'b1; dmem_req = 1'b1;
        wait_done("tie_d");
        chk("tie_first_is_data", {imem_ack, dmem_ack}, 2'b01);
        step(); dmem_req = 1'b0;
        @(negedge clk);
        chk("tie_idle_gap", {mem_req, arb_gnt}, 3'b000);
        @(negedge clk);
        chk("tie_second_is_instr", {mem_req, arb_gnt, mem_we}, {1'b1, GNT_I, 1'b0});
        wait_done("tie_i");
        step(); imem_req = 1'b0;
        step();

        // data-only write, ack two cycles after mem_req
        ack_delay = 2;
        push_g(GNT_D, 32'h100, 1'b1, 32'hDEAD_BEEF, SZ_WORD);
        push_c(4'b0010, 1'b1, 32'hFFFF_FEFF);
        step();
        dmem_adr = 32'h100; dmem_we = 1'b1; dmem_d = 32'hDEAD_BEEF; dmem_size = SZ_WORD;
        dmem_req = 1'b1;
        @(negedge clk);
        chk("lat_cycle0_req", mem_req, 1'b0);
        @(negedge clk);
        chk("lat_cycle1_req_gnt", {mem_req, arb_gnt}, {1'b1, GNT_D});
        wait_done("data_only");
        step(); dmem_req = 1'b0;
        repeat (3) step();

        // timeout with no ack: err on the fifth busy cycle (count reaches 4)
        ack_delay = -1;
        push_g(GNT_D, 32'h500, 1'b1, 32'hCAFE_F00D, SZ_HALF);
        push_c(4'b0001, 1'b0, 32'h0);
        dmem_adr = 32'h500; dmem_we = 1'b1; dmem_d = 32'hCAFE_F00D; dmem_size = SZ_HALF;
        step(); dmem_req = 1'b1;
        wait_mreq("tmo");
        idx = 0;
        while (!dmem_err && idx < 10) begin
            @(negedge clk);
            idx++;
        end
        chk("tmo_err_cycle", idx, 4);
        // late ack while idle must be ignored
        step(); dmem_req = 1'b0; force_ack = 1'b1;
        @(negedge clk);
        chk("late_ack_ignored", {mem_req, imem_ack, imem_err, dmem_ack, dmem_err}, 5'b00000);
        step(); force_ack = 1'b0;
        step();

        // ack coincides with expiry: ack only
        ack_delay = 4;
        push_g(GNT_D, 32'h600, 1'b0, 32'h0BAD_F00D, SZ_WORD);
        push_c(4'b0010, 1'b1, 32'hFFFF_F9FF);
        dmem_adr = 32'h600; dmem_we = 1'b0; dmem_d = 32'h0BAD_F00D; dmem_size = SZ_WORD;
        step(); dmem_req = 1'b1;
        wait_mreq("tie_tmo");
        wait_done("tie_tmo");
        chk("ack_beats_timeout", {dmem_ack, dmem_err}, 2'b10);
        step(); dmem_req = 1'b0;
        step();

        // reset in the middle of an instruction transaction
        ack_delay = -1;
        push_g(GNT_I, 32'h700, 1'b0, 32'h0BAD_F00D, SZ_WORD);
        imem_adr = 32'h700;
        step(); imem_req = 1'b1;
        wait_mreq("mid_rst");
        @(negedge clk);
        step(); rstn = 1'b0; imem_req = 1'b0; force_err = 1'b1;
        @(negedge clk);
        chk("in_reset_no_pulses", {imem_ack, imem_err, dmem_ack, dmem_err}, 4'b0000);
        @(negedge clk);
        chk("mid_rst_req_gnt", {mem_req, arb_gnt}, 3'b000);
        chk("mid_rst_fields", {mem_we, mem_adr, mem_d, mem_size}, {1'b0, 32'h0, 32'h0, SZ_WORD});
        ack_delay = 1;
        push_g(GNT_I, 32'h800, 1'b0, 32'h0, SZ_WORD);
        push_c(4'b1000, 1'b1, 32'hFFFF_F7FF);
        step(); rstn = 1'b1; force_err = 1'b0;
        imem_adr = 32'h800; imem_req = 1'b1;
        wait_done("post_rst");
        step(); imem_req = 1'b0;
        step();

        // both requesting back-to-back for four transactions
`ifdef ARB_ROUND_ROBIN_EN
        order[0] = GNT_D; order[1] = GNT_I; order[2] = GNT_D; order[3] = GNT_I;
`else
        order[0] = GNT_D; order[1] = GNT_D; order[2] = GNT_D; order[3] = GNT_D;
`endif
        ack_delay = 0;
        for (int k = 0; k < 4; k++) begin
            if (order[k] == GNT_D) begin
                push_g(GNT_D, 32'h80, 1'b0, 32'h1234_5678, SZ_HALF);
                push_c(4'b0010, 1'b1, 32'hFFFF_FF7F);
            end else begin
                push_g(GNT_I, 32'h300, 1'b0, 32'h1234_5678, SZ_WORD);
                push_c(4'b1000, 1'b1, 32'hFFFF_FCFF);
            end
        end
        imem_adr = 32'h300; dmem_adr = 32'h80; dmem_we = 1'b0;
        dmem_d = 32'h1234_5678; dmem_size = SZ_HALF;
        step(); imem_req = 1'b1; dmem_req = 1'b1;
        n_ack = 0; cyc = 0;
        while (n_ack < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (imem_ack | dmem_ack) n_ack++;
        end
        chk("b2b_ack_count", n_ack, 4);
        step(); imem_req = 1'b0; dmem_req = 1'b0;
        repeat (4) step();

        chk("grants_left", exp_g.size(), 0);
        chk("cmpls_left", exp_c.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/biu_arbiter.md
BIU_ARBITER -- requirements
Module: biu_arbiter

Interface
REQ-001 Parameter XLEN, default 32, address and data width.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles a granted transaction waits for mem_ack/mem_err; 0 disables the timeout.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset; synchronous, active-low.
REQ-005 imem_req  input  1  instruction requester: request, held until imem_ack/imem_err.
REQ-006 imem_adr  input  XLEN  instruction fetch address.
REQ-007 imem_q / imem_ack / imem_err  output  XLEN/1/1  read data, completion pulse, error pulse to instruction requester.
REQ-008 dmem_req / dmem_we  input  1/1  data requester: request and write-enable, held until dmem_ack/dmem_err.
REQ-009 dmem_adr / dmem_d  input  XLEN/XLEN  data address, write data.
REQ-010 dmem_size  input  biu_size_t  data access size.
REQ-011 dmem_q / dmem_ack / dmem_err  output  XLEN/1/1  read data, completion pulse, error pulse to data requester.
REQ-012 mem_req / mem_we  output  1/1  shared memory port: request and write-enable.
REQ-013 mem_adr / mem_d  output  XLEN/XLEN  shared port address, write data.
REQ-014 mem_size  output  biu_size_t  shared port access size.
REQ-015 mem_q / mem_ack / mem_err  input  XLEN/1/1  shared port read data, completion, error.
REQ-016 arb_gnt  output  2  current owner: bit0 instruction, bit1 data; one-hot or zero.

Function
REQ-017 The FSM SHALL have states IDLE, BUSY_I and BUSY_D.
REQ-018 In IDLE with any request pending, the winner's adr/d/we/size SHALL be registered onto mem_* and the state SHALL move to BUSY_I or BUSY_D; mem_req SHALL rise on the following cycle.
REQ-019 Instruction grants SHALL drive mem_we=0 and mem_size=WORD, with mem_d unchanged.
REQ-020 In BUSY_x, mem_req and all mem_* fields SHALL be held stable until mem_ack or mem_err.
REQ-021 mem_ack/mem_err SHALL be routed combinationally, in the same cycle, to the owner's ack/err only; the non-owner's ack/err SHALL stay 0.
REQ-022 imem_q and dmem_q SHALL both equal mem_q at all times; ack qualifies validity.
REQ-023 On completion, mem_req SHALL deassert the next cycle and the state SHALL return to IDLE. Every transaction is followed by one mandatory IDLE cycle.
REQ-024 Minimum latency SHALL be 1 cycle from request to mem_req.
REQ-025 A requester dropping req while granted SHALL NOT abort the transaction; completion is still pulsed.
REQ-026 With TIMEOUT>0, a 16-bit counter SHALL clear on grant and increment each BUSY cycle. On reaching TIMEOUT, the owner's err SHALL pulse for one cycle, mem_req SHALL drop and the FSM SHALL return to IDLE.
REQ-027 When mem_ack and the timeout occur in the same cycle, ack SHALL win and no err SHALL be issued.
REQ-028 mem_ack/mem_err arriving in IDLE SHALL be ignored.
REQ-029 arb_gnt SHALL reflect the state registered in REQ-018.

Reset
REQ-030 When rstn=0 at a clock edge, the following SHALL take effect on that edge, including mid-transaction: state=IDLE, mem_req=0, mem_we=0, mem_adr=0, mem_d=0, mem_size=WORD, arb_gnt=0, counter=0, last-grant=instruction.
REQ-031 imem_ack/err and dmem_ack/err SHALL be 0 while in reset.

Configuration
REQ-032 Without ARB_ROUND_ROBIN_EN, data SHALL have fixed priority when both request in IDLE.
REQ-033 With ARB_ROUND_ROBIN_EN defined, a tie SHALL go to the requester not granted last. The last-grant register updates on every grant and resets to instruction, so data wins the first tie.

Structure
REQ-034 The arb_state_t enum SHALL reside in biu_constants_pkg alongside biu_size_t.
REQ-035 The timeout counter SHALL be a sub-module biu_arb_timer (inputs clr, en; output expired).

Verification
REQ-036 Data only: dmem_req=1, adr=0x100, we=1, d=0xDEADBEEF, size=WORD, ack 2 cycles after mem_req -> mem_req at cycle 1 with those fields; dmem_ack pulses once; arb_gnt=2'b10.
REQ-037 Simultaneous imem_req (adr=0x200) and dmem_req (adr=0x40) -> data served first. Then: instruction served second, mem_adr=0x200, mem_we=0, with 1 IDLE cycle between.
REQ-038 With ARB_ROUND_ROBIN_EN, both requesters continuously requesting for 4 transactions -> grant order D,I,D,I.
REQ-039 TIMEOUT=4, no mem_ack -> dmem_err pulses after 4 BUSY cycles; a late mem_ack in IDLE produces no ack; mem_ack in the same cycle as expiry -> ack only.
REQ-040 rstn=0 during BUSY_I -> next edge mem_req=0, arb_gnt=0; after release, a fresh imem_req is granted normally.
